// File: rtl/serv_rf_ram_clr.sv
// SERV register-file RAM that zero-fills itself after reset before accepting traffic.
// Optional per-word parity (storage plus read-side check) is enabled by defining SERV_RF_RAM_PARITY_EN.
module serv_rf_ram_clr #(
    parameter int width    = 8,
    parameter int csr_regs = 4,
    parameter int depth    = 32*(32+csr_regs)/width,
    parameter int aw       = $clog2(depth)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [aw-1:0]    i_waddr,
    input  logic [width-1:0] i_wdata,
    input  logic             i_wen,
    input  logic [aw-1:0]    i_raddr,
    input  logic             i_ren,
    output logic [width-1:0] o_rdata,
    output logic             o_init_done,
    output logic             o_perr
);

    // Words holding x0 are never written and always read back as zero.
    localparam logic [aw:0]   X0_WORDS = (aw+1)'(32/width);
    localparam logic [aw:0]   DEPTH_A  = (aw+1)'(depth);
    localparam logic [aw-1:0] LAST     = aw'(depth-1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [aw-1:0]      r_clr_cnt;
    logic [aw-1:0]      w_clr_cnt_nxt;
    logic [width-1:0]   r_mem [0:depth-1];
    logic [width-1:0]   r_rdata;
    logic               w_we;
    logic [aw-1:0]      w_waddr;
    logic [width-1:0]   w_wdata;
    logic               w_waddr_ok;
    logic               w_raddr_ok;

    assign w_waddr_ok = ({1'b0, i_waddr} >= X0_WORDS) && ({1'b0, i_waddr} < DEPTH_A);
    assign w_raddr_ok = ({1'b0, i_raddr} >= X0_WORDS) && ({1'b0, i_raddr} < DEPTH_A);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // The sweep owns the write port until the last word is zeroed.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_we          = 1'b0;
        w_waddr       = i_waddr;
        w_wdata       = i_wdata;
        case (r_state)
            CLEAR: begin
                w_we          = !i_rst;
                w_waddr       = r_clr_cnt;
                w_wdata       = '0;
                w_clr_cnt_nxt = r_clr_cnt + aw'(1);
                if (r_clr_cnt == LAST) begin
                    w_state_nxt   = RUN;
                    w_clr_cnt_nxt = '0;
                end
            end
            RUN: begin
                w_we = !i_rst && i_wen && w_waddr_ok;
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Non-blocking read of the array gives read-before-write on a same-address collision.
    always_ff @(posedge i_clk) begin
        if (i_rst || r_state == CLEAR) begin
            r_rdata <= '0;
        end else if (i_ren) begin
            r_rdata <= w_raddr_ok ? r_mem[i_raddr] : '0;
        end
    end

    assign o_rdata     = r_rdata;
    assign o_init_done = (r_state == RUN);

`ifdef SERV_RF_RAM_PARITY_EN
    logic r_par [0:depth-1];
    logic r_perr;

    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_par[w_waddr] <= ^w_wdata;
        end
    end

    // Flag lasts exactly the cycle the corresponding o_rdata value appears.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= (r_state == RUN) && i_ren && w_raddr_ok &&
                      ((^r_mem[i_raddr]) != r_par[i_raddr]);
        end
    end

    assign o_perr = r_perr;
`else
    assign o_perr = 1'b0;
`endif

endmodule

// File: tb/tb_serv_rf_ram_clr.sv
// Directed bench for serv_rf_ram_clr: clear sweep, reads/writes, x0 and range rules, reset restart.
// Reads push {perr, data} to a scoreboard queue and are compared one cycle later.
module tb_serv_rf_ram_clr;
    localparam int W  = 8;
    localparam int D  = 144;
    localparam int AW = 8;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [AW-1:0] i_waddr = '0;
    logic [W-1:0]  i_wdata = '0;
    logic          i_wen = 1'b0;
    logic [AW-1:0] i_raddr = '0;
    logic          i_ren = 1'b0;
    logic [W-1:0]  o_rdata;
    logic          o_init_done;
    logic          o_perr;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [W:0]    exp_q[$];
    logic [W-1:0]  model [0:255];
    logic [W-1:0]  last_rdata;
    int            n_edges;

    serv_rf_ram_clr #(.width(W), .csr_regs(4)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_waddr     (i_waddr),
        .i_wdata     (i_wdata),
        .i_wen       (i_wen),
        .i_raddr     (i_raddr),
        .i_ren       (i_ren),
        .o_rdata     (o_rdata),
        .o_init_done (o_init_done),
        .o_perr      (o_perr)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // One cycle of traffic; a read is scored against the model value before any same-edge write.
    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                         input logic re, input logic [AW-1:0] ra, input logic pe);
        logic [W:0] e;
        i_wen = we; i_waddr = wa; i_wdata = wd;
        i_ren = re; i_raddr = ra;
        if (re) exp_q.push_back({pe, model[ra]});
        step();
        if (we && wa >= 4 && wa < D) model[wa] = wd;
        i_wen = 1'b0; i_ren = 1'b0;
        if (re) begin
            e = exp_q.pop_front();
            check($sformatf("rdata@%0h", ra), {24'd0, o_rdata}, {24'd0, e[W-1:0]});
            check($sformatf("perr@%0h", ra), {31'd0, o_perr}, {31'd0, e[W]});
            last_rdata = e[W-1:0];
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
        drive(1'b1, a, d, 1'b0, '0, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        drive(1'b0, '0, '0, 1'b1, a, 1'b0);
    endtask

    // Runs the sweep with write/read requests held active; they must have no effect.
    task automatic sweep(output int n);
        n = 0;
        i_wen = 1'b1; i_waddr = 8'h50; i_wdata = 8'h77;
        i_ren = 1'b1; i_raddr = 8'h10;
        while (n < 1000) begin
            step();
            n++;
            if (o_init_done) break;
            if (n % 16 == 1) check("clear_rdata", {24'd0, o_rdata}, 32'd0);
        end
        i_wen = 1'b0; i_ren = 1'b0;
        for (int k = 0; k < 256; k++) model[k] = '0;
    endtask

    initial begin
        for (int k = 0; k < 256; k++) model[k] = '0;
        last_rdata = '0;

        repeat (3) step();
        check("rst_init_done", {31'd0, o_init_done}, 32'd0);
        check("rst_rdata", {24'd0, o_rdata}, 32'd0);
        check("rst_perr", {31'd0, o_perr}, 32'd0);

        i_rst = 1'b0;
        sweep(n_edges);
        check("init_edges", n_edges, 32'd144);

        for (int a = 0; a < D; a++) rd(AW'(a));
        rd(8'hC8);

        wr(8'h10, 8'hA5);
        rd(8'h10);
        wr(8'h02, 8'hFF);
        rd(8'h02);
        wr(8'h00, 8'h5C);
        rd(8'h00);
        wr(8'hA0, 8'h3C);
        rd(8'hA0);
        rd(8'h50);

        wr(8'h20, 8'h11);
        drive(1'b1, 8'h20, 8'h22, 1'b1, 8'h20, 1'b0);
        rd(8'h20);

        drive(1'b1, 8'h21, 8'h5A, 1'b1, 8'h10, 1'b0);
        rd(8'h21);

        repeat (3) begin
            drive(1'b1, 8'h22, 8'h99, 1'b0, 8'h22, 1'b0);
            check("hold_rdata", {24'd0, o_rdata}, {24'd0, last_rdata});
        end
        rd(8'h8F);

        for (int k = 0; k < 40; k++) begin
            drive(1'b1, AW'($urandom_range(0, 150)), W'($urandom_range(0, 255)),
                  1'b1, AW'($urandom_range(0, 255)), 1'b0);
        end
        for (int a = 4; a < 12; a++) rd(AW'(a));

        wr(8'h40, 8'h33);
        rd(8'h40);
        i_rst = 1'b1;
        step();
        check("rst_run_init_done", {31'd0, o_init_done}, 32'd0);
        check("rst_run_rdata", {24'd0, o_rdata}, 32'd0);
        i_rst = 1'b0;
        repeat (50) step();
        check("mid_clear_init_done", {31'd0, o_init_done}, 32'd0);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        sweep(n_edges);
        check("restart_edges", n_edges, 32'd144);
        rd(8'h40);
        rd(8'h10);
        rd(8'h8F);

`ifdef SERV_RF_RAM_PARITY_EN
        wr(8'h30, 8'h6B);
        rd(8'h30);
        dut.r_mem[8'h30] = dut.r_mem[8'h30] ^ 8'h01;
        model[8'h30] = model[8'h30] ^ 8'h01;
        drive(1'b0, '0, '0, 1'b1, 8'h30, 1'b1);
        step();
        check("perr_one_cycle", {31'd0, o_perr}, 32'd0);
        rd(8'h31);
        rd(8'h02);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/serv_rf_ram_clr.md
SERV_RF_RAM_CLR -- requirements
Module: serv_rf_ram_clr

Interface
REQ-001 Parameter: width, default 8, RAM data width in bits (power of two, 2..32).
REQ-002 Parameter: csr_regs, default 4, number of CSR registers stored after the 32 GPRs.
REQ-003 Parameter: depth, default 32*(32+csr_regs)/width, number of RAM words (144 at defaults).
REQ-004 Parameter: aw, default $clog2(depth), address width (8 at defaults).
REQ-005 Reset and clock SHALL be: reset i_rst, synchronous, active-high; clock i_clk.
REQ-006 i_clk  in  1  clock.
REQ-007 i_rst  in  1  synchronous active-high reset.
REQ-008 i_waddr  in  aw  write word address.
REQ-009 i_wdata  in  width  write data.
REQ-010 i_wen  in  1  write enable.
REQ-011 i_raddr  in  aw  read word address.
REQ-012 i_ren  in  1  read enable.
REQ-013 o_rdata  out  width  registered read data.
REQ-014 o_init_done  out  1  high once the clear sweep has finished.
REQ-015 o_perr  out  1  parity-error pulse, aligned with o_rdata.

Function
REQ-016 The block SHALL implement a two-state FSM with states CLEAR and RUN, plus a clear counter clr_cnt[aw-1:0].
REQ-017 In CLEAR, each clock edge SHALL write zero (and, under the macro, parity 0) at address clr_cnt, then increment clr_cnt.
REQ-018 The edge that writes address depth-1 SHALL move the FSM to RUN; a full clear takes exactly depth edges.
REQ-019 In CLEAR: i_wen and i_ren ignored; o_rdata held at 0; o_init_done=0.
REQ-020 In RUN: o_init_done=1.
REQ-021 In RUN, i_wen=1 SHALL write i_wdata at i_waddr on that edge.
REQ-022 Writes with i_waddr>=depth SHALL be dropped.
REQ-023 Writes with i_waddr < 32/width (the x0 words) SHALL be dropped.
REQ-024 Read latency SHALL be 1 cycle: i_ren=1 at edge N gives data on o_rdata after edge N.
REQ-025 When i_ren=0, o_rdata SHALL hold its previous value.
REQ-026 Reads of x0 words or of i_raddr>=depth SHALL return 0.
REQ-027 Read and write to the same address on the same edge SHALL return the old data (read-before-write).
REQ-028 Simultaneous read and write to different addresses SHALL both complete in one cycle.
REQ-029 The block SHALL never stall; no ready/busy handshake exists other than o_init_done.

Reset
REQ-030 i_rst=1 SHALL force: FSM=CLEAR, clr_cnt=0, o_rdata=0, o_init_done=0, o_perr=0.
REQ-031 Reset asserted mid-clear or in RUN SHALL restart the sweep from address 0; RAM contents are not otherwise reset.

Configuration
REQ-032 Macro: SERV_RF_RAM_PARITY_EN.
REQ-033 Macro defined: each word stores one extra bit equal to the XOR of its width data bits.
REQ-034 Macro defined: on each read, o_perr SHALL be 1 for exactly the cycle o_rdata is updated if the recomputed parity mismatches the stored bit; x0 and out-of-range reads SHALL never flag.
REQ-035 Macro undefined: no parity storage; o_perr tied to 0.

Verification (width=8, csr_regs=4)
REQ-036 Release reset, then count edges -> o_init_done rises after exactly 144 edges; reading addresses 0..143 then returns 0x00.
REQ-037 Write 0xA5 at address 0x10, then read 0x10 on the next cycle -> o_rdata=0xA5 one cycle after i_ren.
REQ-038 Write 0xFF at address 0x02, then read 0x02 -> o_rdata=0x00.
REQ-039 With 0x11 stored at 0x20, write 0x22 at 0x20 while reading 0x20 on the same edge -> o_rdata=0x11; the next read returns 0x22.
REQ-040 Assert i_rst at clear edge 50, after 0x33 was written at 0x40 in a previous RUN -> sweep restarts; o_init_done is low for 144 edges after release; 0x40 reads 0x00.
REQ-041 Macro defined: force-flip one stored data bit at 0x30, then read 0x30 -> o_perr=1 for one cycle; reading an untouched word gives o_perr=0.
